// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt sequencer.
package pic_pkg;

  localparam int unsigned NUM_IR     = 8;
  localparam int unsigned VEC_BASE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK1,
    ST_ACK2
  } pic_state_e;

  // OCW2 {R,SL,EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // Rank 0 is the highest priority: the line just after LP.
  function automatic logic [2:0] pic_rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority find-first: returns the highest-priority set bit given LP.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [2:0] i_lp,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  logic [7:0] w_rot;
  logic [2:0] w_pos;

  always_comb begin
    w_rot   = '0;
    w_pos   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < NUM_IR; k++) begin
      w_pos    = i_lp + 3'd1 + k[2:0];
      w_rot[k] = i_req[w_pos];
    end
    for (int unsigned k = 0; k < NUM_IR; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        o_idx   = i_lp + 3'd1 + k[2:0];
      end
    end
  end

endmodule

// File: rtl/pic_priority_scheduler.sv
// 8259-style request latching, nested priority resolution, INTA handshake and OCW2 EOI handling.
module pic_priority_scheduler #(
  parameter int unsigned NUM_IR     = 8,
  parameter int unsigned VEC_BASE_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_IR-1:0]     IR,
  input  logic                  LTIM,
  input  logic                  AEOI,
  input  logic [VEC_BASE_W-1:0] VEC_BASE,
  input  logic [NUM_IR-1:0]     IMR,
  input  logic                  EOI_VALID,
  input  logic [2:0]            EOI_CODE,
  input  logic [2:0]            EOI_LEVEL,
  input  logic                  INTA_N,
  output logic                  INT,
  output logic                  VEC_VALID,
  output logic [7:0]            VECTOR,
  output logic [NUM_IR-1:0]     IRR,
  output logic [NUM_IR-1:0]     ISR
);

  import pic_pkg::*;

  pic_state_e  r_state, w_next_state;
  logic [7:0]  r_ir_prev, r_irr, r_isr;
  logic        r_inta_prev, r_rot_aeoi, r_int, r_vec_valid;
  logic [2:0]  r_lp, r_w;
  logic [7:0]  r_vector;

  logic        w_inta_fall, w_inta_rise;
  logic        w_ack_take, w_vec_load, w_ack_done;
  logic        w_cand_valid, w_isr_valid, w_int_req;
  logic [2:0]  w_cand_idx, w_isr_idx, w_lp_next;
  logic        w_rot_aeoi_next;
  logic [7:0]  w_irr_next, w_isr_set, w_isr_clr;

  assign w_inta_fall = r_inta_prev & ~INTA_N;
  assign w_inta_rise = ~r_inta_prev & INTA_N;

  pic_priority_resolver u_req_res (
    .i_req  (r_irr & ~IMR),
    .i_lp   (r_lp),
    .o_valid(w_cand_valid),
    .o_idx  (w_cand_idx)
  );

  pic_priority_resolver u_isr_res (
    .i_req  (r_isr),
    .i_lp   (r_lp),
    .o_valid(w_isr_valid),
    .o_idx  (w_isr_idx)
  );

  assign w_int_req = w_cand_valid &&
                     (!w_isr_valid || (pic_rank(w_cand_idx, r_lp) < pic_rank(w_isr_idx, r_lp)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_inta_fall) w_next_state = ST_ACK1;
      ST_ACK1: if (w_inta_fall) w_next_state = ST_ACK2;
      ST_ACK2: if (w_inta_rise) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A fall seen in ACK1 always implies an intervening rise, so no extra flag is needed.
  always_comb begin
    w_ack_take = (r_state == ST_IDLE) && w_inta_fall;
    w_vec_load = (r_state == ST_ACK1) && w_inta_fall;
    w_ack_done = (r_state == ST_ACK2) && w_inta_rise;
  end

  always_comb begin
    w_irr_next = LTIM ? IR : (IR & (r_irr | ~r_ir_prev));
    w_isr_set  = '0;
    if (w_ack_take && w_cand_valid) begin
      w_irr_next[w_cand_idx] = 1'b0;
      w_isr_set[w_cand_idx]  = 1'b1;
    end
  end

  // AEOI rotation is applied first so an OCW2 rotate in the same cycle takes precedence.
  always_comb begin
    w_isr_clr       = '0;
    w_lp_next       = r_lp;
    w_rot_aeoi_next = r_rot_aeoi;
    if (w_ack_done && AEOI) begin
      w_isr_clr[r_w] = 1'b1;
      if (r_rot_aeoi) w_lp_next = r_w;
    end
    if (EOI_VALID) begin
      case (EOI_CODE)
        OCW2_NS_EOI:       if (w_isr_valid) w_isr_clr[w_isr_idx] = 1'b1;
        OCW2_SP_EOI:       w_isr_clr[EOI_LEVEL] = 1'b1;
        OCW2_ROT_NS_EOI:   if (w_isr_valid) begin
                             w_isr_clr[w_isr_idx] = 1'b1;
                             w_lp_next            = w_isr_idx;
                           end
        OCW2_ROT_SP_EOI:   begin
                             w_isr_clr[EOI_LEVEL] = 1'b1;
                             w_lp_next            = EOI_LEVEL;
                           end
        OCW2_SET_PRIO:     w_lp_next = EOI_LEVEL;
        OCW2_ROT_AEOI_SET: w_rot_aeoi_next = 1'b1;
        OCW2_ROT_AEOI_CLR: w_rot_aeoi_next = 1'b0;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ir_prev   <= '0;
      r_inta_prev <= 1'b1;
      r_irr       <= '0;
      r_isr       <= '0;
      r_lp        <= 3'd7;
      r_rot_aeoi  <= 1'b0;
      r_w         <= '0;
      r_int       <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vector    <= '0;
    end else begin
      r_ir_prev   <= IR;
      r_inta_prev <= INTA_N;
      r_irr       <= w_irr_next;
      r_isr       <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_lp        <= w_lp_next;
      r_rot_aeoi  <= w_rot_aeoi_next;
      r_int       <= (r_state == ST_IDLE) && !w_inta_fall && w_int_req;
      if (w_ack_take) r_w <= w_cand_valid ? w_cand_idx : 3'd7;
      if (w_vec_load) begin
        r_vector    <= {VEC_BASE, r_w};
        r_vec_valid <= 1'b1;
      end else if (w_ack_done) begin
        r_vec_valid <= 1'b0;
      end
    end
  end

  assign INT       = r_int;
  assign VEC_VALID = r_vec_valid;
  assign VECTOR    = r_vector;
  assign IRR       = r_irr;
  assign ISR       = r_isr;

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Directed bench for pic_priority_scheduler with hand-computed expectations.
module tb_pic_priority_scheduler;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IR;
  logic       LTIM, AEOI;
  logic [4:0] VEC_BASE;
  logic [7:0] IMR;
  logic       EOI_VALID;
  logic [2:0] EOI_CODE, EOI_LEVEL;
  logic       INTA_N;
  logic       INT, VEC_VALID;
  logic [7:0] VECTOR, IRR, ISR;

  int n_vec  = 0;
  int n_fail = 0;

  pic_priority_scheduler #(.NUM_IR(8), .VEC_BASE_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .LTIM(LTIM), .AEOI(AEOI),
    .VEC_BASE(VEC_BASE), .IMR(IMR), .EOI_VALID(EOI_VALID), .EOI_CODE(EOI_CODE),
    .EOI_LEVEL(EOI_LEVEL), .INTA_N(INTA_N), .INT(INT), .VEC_VALID(VEC_VALID),
    .VECTOR(VECTOR), .IRR(IRR), .ISR(ISR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic eoi(input logic [2:0] code, input logic [2:0] lvl);
    EOI_VALID = 1'b1;
    EOI_CODE  = code;
    EOI_LEVEL = lvl;
    tick();
    EOI_VALID = 1'b0;
  endtask

  task automatic do_ack(input string tag, input logic [7:0] exp_vec);
    INTA_N = 1'b0; tick();
    chk({tag, "_int_drop"}, {7'd0, INT}, 8'h00);
    INTA_N = 1'b1; tick();
    INTA_N = 1'b0; tick();
    chk({tag, "_vvalid"}, {7'd0, VEC_VALID}, 8'h01);
    chk({tag, "_vector"}, VECTOR, exp_vec);
    INTA_N = 1'b1; tick();
    chk({tag, "_vvalid_off"}, {7'd0, VEC_VALID}, 8'h00);
  endtask

  initial begin
    RST_N = 1'b0; IR = '0; LTIM = 1'b0; AEOI = 1'b0; VEC_BASE = 5'b10111;
    IMR = '0; EOI_VALID = 1'b0; EOI_CODE = '0; EOI_LEVEL = '0; INTA_N = 1'b1;
    tick(); tick();
    RST_N = 1'b1;
    chk("rst_int", {7'd0, INT}, 8'h00);
    chk("rst_vvalid", {7'd0, VEC_VALID}, 8'h00);
    chk("rst_vector", VECTOR, 8'h00);
    chk("rst_irr", IRR, 8'h00);
    chk("rst_isr", ISR, 8'h00);

    // 1: IR3 edge, two-cycle INT latency, full ack
    IR = 8'h08; tick();
    chk("t1_irr", IRR, 8'h08);
    chk("t1_int_n1", {7'd0, INT}, 8'h00);
    tick();
    chk("t1_int_n2", {7'd0, INT}, 8'h01);
    do_ack("t1", 8'hBB);
    chk("t1_isr", ISR, 8'h08);
    chk("t1_irr_after", IRR, 8'h00);
    IR = 8'h00; tick();

    // 2: nesting against ISR3
    IR = 8'h20; tick(); tick(); tick();
    chk("t2_ir5_blocked", {7'd0, INT}, 8'h00);
    IR = 8'h22; tick(); tick();
    chk("t2_ir1_int", {7'd0, INT}, 8'h01);
    do_ack("t2", 8'hB9);
    chk("t2_isr", ISR, 8'h0A);
    tick();
    chk("t2_int_nested", {7'd0, INT}, 8'h00);
    IR = 8'h00; tick();
    eoi(3'b011, 3'd3);
    chk("t2_sp_eoi", ISR, 8'h02);
    eoi(3'b001, 3'd0);
    chk("t2_ns_eoi", ISR, 8'h00);
    eoi(3'b001, 3'd0);
    chk("t2_ns_eoi_empty", ISR, 8'h00);

    // 3: masking
    IMR = 8'h02; IR = 8'h02; tick(); tick();
    chk("t3_masked_int", {7'd0, INT}, 8'h00);
    IMR = 8'h00; tick(); tick();
    chk("t3_unmasked_int", {7'd0, INT}, 8'h01);
    do_ack("t3", 8'hB9);
    IR = 8'h00; tick();
    eoi(3'b001, 3'd0);
    chk("t3_isr_clear", ISR, 8'h00);

    // 4: rotation via EOI 101
    IR = 8'h44; tick(); tick();
    do_ack("t4a", 8'hBA);
    chk("t4_isr", ISR, 8'h04);
    chk("t4_irr", IRR, 8'h40);
    eoi(3'b101, 3'd0);
    chk("t4_rot_eoi", ISR, 8'h00);
    IR = 8'h41; tick(); tick();
    chk("t4_irr2", IRR, 8'h41);
    do_ack("t4b", 8'hBE);
    chk("t4_isr2", ISR, 8'h40);
    IR = 8'h00; tick();
    eoi(3'b001, 3'd0);
    eoi(3'b110, 3'd7);
    chk("t4_isr_clear", ISR, 8'h00);

    // 5: AEOI, then spurious
    AEOI = 1'b1;
    IR = 8'h10; tick(); tick();
    INTA_N = 1'b0; tick();
    chk("t5_isr_set", ISR, 8'h10);
    INTA_N = 1'b1; tick();
    INTA_N = 1'b0; tick();
    chk("t5_vector", VECTOR, 8'hBC);
    INTA_N = 1'b1; tick();
    chk("t5_aeoi_isr", ISR, 8'h00);
    AEOI = 1'b0; IR = 8'h00; tick();
    IR = 8'h04; tick(); tick();
    chk("t5_sp_int", {7'd0, INT}, 8'h01);
    IR = 8'h00; tick();
    chk("t5_sp_irr", IRR, 8'h00);
    do_ack("t5sp", 8'hBF);
    chk("t5_sp_isr", ISR, 8'h00);

    // 6: async reset mid-acknowledge
    IR = 8'h08; tick(); tick();
    INTA_N = 1'b0; tick();
    chk("t6_isr_ack1", ISR, 8'h08);
    RST_N = 1'b0; #1;
    chk("t6_rst_int", {7'd0, INT}, 8'h00);
    chk("t6_rst_vvalid", {7'd0, VEC_VALID}, 8'h00);
    chk("t6_rst_isr", ISR, 8'h00);
    IR = 8'h00; INTA_N = 1'b1; tick();
    RST_N = 1'b1; tick();
    IR = 8'h20; tick(); tick();
    chk("t6_int", {7'd0, INT}, 8'h01);
    do_ack("t6", 8'hBD);
    chk("t6_isr", ISR, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
